// File: rtl/mem_port_arbiter_if.sv
// Bundled signals of the two-master memory data-port arbiter: master-side
// request/grant/read-return channels and the shared memory data port.
interface mem_port_arbiter_if;
  // Handshake: a master raises req with addr/wdata/wmask stable and holds them
  // until gnt; the access happens on the rising edge where req && gnt. A read
  // granted in cycle N returns rdata qualified by rvalid in cycle N+1.
  logic        m0_req;
  logic        m0_lock;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wmask;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_lock;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wmask;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_data;

  modport slave (
    input  m0_req, m0_lock, m0_addr, m0_wdata, m0_wmask,
    input  m1_req, m1_lock, m1_addr, m1_wdata, m1_wmask,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_wmask,
    input  mem_data
  );

  modport master (
    output m0_req, m0_lock, m0_addr, m0_wdata, m0_wmask,
    output m1_req, m1_lock, m1_addr, m1_wdata, m1_wmask,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_wmask,
    output mem_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with bounded lock sharing the unified memory data port
// between the load/store unit (master 0) and the debug loader (master 1).
module mem_port_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  mem_port_arbiter_if.slave         bus,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [7:0] MAX_HOLD8 = 8'(MAX_HOLD);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  hold_q, hold_d;

  logic        gnt_any;
  logic        sel;
  logic        gnt_ok;
  logic        sel_lock;
  logic        other_req;
  logic        owner_kept;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wmask;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rd_pend_q;
  logic        rd_owner_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_d     = hold_q;
    gnt_any    = 1'b0;
    sel        = 1'b0;
    sel_lock   = 1'b0;
    other_req  = 1'b0;
    owner_kept = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          gnt_any = 1'b1;
          sel     = ~last_q;
        end else if (bus.m0_req) begin
          gnt_any = 1'b1;
          sel     = 1'b0;
        end else if (bus.m1_req) begin
          gnt_any = 1'b1;
          sel     = 1'b1;
        end
      end
      LOCK0: begin
        // The holder wins unless it has used up its contested budget.
        if (bus.m0_req) begin
          gnt_any = 1'b1;
          sel     = (hold_q == MAX_HOLD8) && bus.m1_req;
        end else if (bus.m1_req) begin
          gnt_any = 1'b1;
          sel     = 1'b1;
        end
      end
      LOCK1: begin
        if (bus.m1_req) begin
          gnt_any = 1'b1;
          sel     = !((hold_q == MAX_HOLD8) && bus.m0_req);
        end else if (bus.m0_req) begin
          gnt_any = 1'b1;
          sel     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (gnt_any) begin
      last_d     = sel;
      sel_lock   = sel ? bus.m1_lock : bus.m0_lock;
      other_req  = sel ? bus.m0_req : bus.m1_req;
      owner_kept = ((state_q == LOCK0) && !sel) || ((state_q == LOCK1) && sel);
      if (owner_kept) begin
        if (sel_lock) begin
          // Only contested grants consume budget; uncontested locks never expire.
          if (other_req && (hold_q < MAX_HOLD8)) begin
            hold_d = hold_q + 8'd1;
          end
        end else begin
          state_d = IDLE;
          hold_d  = 8'd0;
        end
      end else if (state_q == IDLE) begin
        if (sel_lock) begin
          state_d = sel ? LOCK1 : LOCK0;
          hold_d  = 8'd1;
        end
      end else begin
        state_d = IDLE;
        hold_d  = 8'd0;
      end
    end else if (state_q != IDLE) begin
      state_d = IDLE;
      hold_d  = 8'd0;
    end
  end

  assign gnt_ok    = gnt_any && !reset;
  assign sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
  assign sel_wmask = sel ? bus.m1_wmask : bus.m0_wmask;

  assign bus.m0_gnt = gnt_ok && !sel;
  assign bus.m1_gnt = gnt_ok && sel;

  // Ungranted cycles keep the last address/data on the port and never write.
  assign bus.mem_addr  = gnt_ok ? sel_addr  : addr_q;
  assign bus.mem_wdata = gnt_ok ? sel_wdata : wdata_q;
  assign bus.mem_wmask = gnt_ok ? sel_wmask : 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q <= gnt_ok && (sel_wmask == 4'd0);
      if (gnt_ok) begin
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
        rd_owner_q <= sel;
      end
    end
  end

  assign bus.m0_rvalid = rd_pend_q && !rd_owner_q;
  assign bus.m1_rvalid = rd_pend_q && rd_owner_q;
  assign bus.m0_rdata  = bus.mem_data;
  assign bus.m1_rdata  = bus.mem_data;

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus
// hand-written sequences for lock budget, uncontested lock and lock release.
module tb_mem_port_arbiter;

  localparam int unsigned MAX_HOLD = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  logic       mem_load;
  logic [31:0] mem_arr [0:255];

  int compared;
  int mismatched;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read of the old contents, byte-masked writes.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'd0;
      mem_arr[0]   <= 32'hA0A0A0A0;
      mem_arr[1]   <= 32'hB4B4B4B4;
      mem_arr[16]  <= 32'hDEADBEEF;
      mem_arr[128] <= 32'h11223344;
      mem_arr[192] <= 32'hC0FFEE00;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wmask[b]) mem_arr[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
    bus.mem_data <= mem_arr[bus.mem_addr[9:2]];
  end

  typedef struct {
    logic        rst;
    logic        r0;
    logic [31:0] a0;
    logic [3:0]  wm0;
    logic [31:0] wd0;
    logic        r1;
    logic [31:0] a1;
    logic        e_g0;
    logic        e_g1;
    logic        e_rv0;
    logic        e_rv1;
    logic [31:0] e_rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_wmask;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic r0, logic [31:0] a0, logic [3:0] wm0,
                              logic [31:0] wd0, logic r1, logic [31:0] a1,
                              logic e_g0, logic e_g1, logic e_rv0, logic e_rv1,
                              logic [31:0] e_rdata, logic [31:0] e_addr, logic [3:0] e_wmask);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.a0 = a0; v.wm0 = wm0; v.wd0 = wd0; v.r1 = r1; v.a1 = a1;
    v.e_g0 = e_g0; v.e_g1 = e_g1; v.e_rv0 = e_rv0; v.e_rv1 = e_rv1;
    v.e_rdata = e_rdata; v.e_addr = e_addr; v.e_wmask = e_wmask;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    bus.m0_req = 1'b0; bus.m0_lock = 1'b0; bus.m0_addr = 32'd0; bus.m0_wdata = 32'd0; bus.m0_wmask = 4'd0;
    bus.m1_req = 1'b0; bus.m1_lock = 1'b0; bus.m1_addr = 32'd0; bus.m1_wdata = 32'd0; bus.m1_wmask = 4'd0;
  endtask

  task automatic drive_vec(input vec_t v);
    drive_idle();
    reset         = v.rst;
    bus.m0_req    = v.r0;
    bus.m0_addr   = v.a0;
    bus.m0_wmask  = v.wm0;
    bus.m0_wdata  = v.wd0;
    bus.m1_req    = v.r1;
    bus.m1_addr   = v.a1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    mem_load   = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    mem_load = 1'b0;

    //        rst r0 a0            wm0    wd0            r1 a1      g0 g1 rv0 rv1 rdata          addr           wmask
    vecs.push_back(mk(1, 1, 32'h40,  4'hF,  32'h0,         0, 32'h0,  0, 0, 0, 0, 32'h0,         32'h0,   4'h0));
    vecs.push_back(mk(0, 1, 32'h40,  4'h0,  32'h0,         0, 32'h0,  1, 0, 0, 0, 32'h0,         32'h40,  4'h0));
    vecs.push_back(mk(0, 0, 32'h0,   4'h0,  32'h0,         0, 32'h0,  0, 0, 1, 0, 32'hDEADBEEF,  32'h40,  4'h0));
    vecs.push_back(mk(1, 0, 32'h0,   4'h0,  32'h0,         0, 32'h0,  0, 0, 0, 0, 32'h0,         32'h0,   4'h0));
    vecs.push_back(mk(0, 1, 32'h0,   4'h0,  32'h0,         1, 32'h4,  1, 0, 0, 0, 32'h0,         32'h0,   4'h0));
    vecs.push_back(mk(0, 1, 32'h0,   4'h0,  32'h0,         1, 32'h4,  0, 1, 1, 0, 32'hA0A0A0A0,  32'h4,   4'h0));
    vecs.push_back(mk(0, 1, 32'h0,   4'h0,  32'h0,         1, 32'h4,  1, 0, 0, 1, 32'hB4B4B4B4,  32'h0,   4'h0));
    vecs.push_back(mk(0, 1, 32'h0,   4'h0,  32'h0,         1, 32'h4,  0, 1, 1, 0, 32'hA0A0A0A0,  32'h4,   4'h0));
    vecs.push_back(mk(0, 0, 32'h0,   4'h0,  32'h0,         0, 32'h0,  0, 0, 0, 1, 32'hB4B4B4B4,  32'h4,   4'h0));
    vecs.push_back(mk(0, 1, 32'h200, 4'h2,  32'h0000AB00,  0, 32'h0,  1, 0, 0, 0, 32'h0,         32'h200, 4'h2));
    vecs.push_back(mk(0, 1, 32'h200, 4'h0,  32'h0,         0, 32'h0,  1, 0, 0, 0, 32'h0,         32'h200, 4'h0));
    vecs.push_back(mk(0, 0, 32'h0,   4'h0,  32'h0,         0, 32'h0,  0, 0, 1, 0, 32'h1122AB44,  32'h200, 4'h0));
    vecs.push_back(mk(0, 0, 32'h0,   4'h0,  32'h0,         1, 32'h300, 0, 1, 0, 0, 32'h0,        32'h300, 4'h0));
    vecs.push_back(mk(0, 0, 32'h0,   4'h0,  32'h0,         0, 32'h0,  0, 0, 0, 1, 32'hC0FFEE00,  32'h300, 4'h0));
    vecs.push_back(mk(0, 0, 32'h0,   4'h0,  32'h0,         0, 32'h0,  0, 0, 0, 0, 32'h0,         32'h300, 4'h0));
    vecs.push_back(mk(0, 1, 32'h300, 4'h0,  32'h0,         0, 32'h0,  1, 0, 0, 0, 32'h0,         32'h300, 4'h0));
    vecs.push_back(mk(1, 1, 32'h300, 4'hF,  32'h12345678,  0, 32'h0,  0, 0, 0, 0, 32'h0,         32'h0,   4'h0));
    vecs.push_back(mk(0, 1, 32'h0,   4'h0,  32'h0,         1, 32'h4,  1, 0, 0, 0, 32'h0,         32'h0,   4'h0));
    vecs.push_back(mk(0, 0, 32'h0,   4'h0,  32'h0,         0, 32'h0,  0, 0, 1, 0, 32'hA0A0A0A0,  32'h0,   4'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      check($sformatf("v%0d_gnt0", i),  {31'd0, bus.m0_gnt},    {31'd0, vecs[i].e_g0});
      check($sformatf("v%0d_gnt1", i),  {31'd0, bus.m1_gnt},    {31'd0, vecs[i].e_g1});
      check($sformatf("v%0d_rv0", i),   {31'd0, bus.m0_rvalid}, {31'd0, vecs[i].e_rv0});
      check($sformatf("v%0d_rv1", i),   {31'd0, bus.m1_rvalid}, {31'd0, vecs[i].e_rv1});
      check($sformatf("v%0d_addr", i),  bus.mem_addr,           vecs[i].e_addr);
      check($sformatf("v%0d_wmask", i), {28'd0, bus.mem_wmask}, {28'd0, vecs[i].e_wmask});
      if (vecs[i].e_rv0) check($sformatf("v%0d_rdata0", i), bus.m0_rdata, vecs[i].e_rdata);
      if (vecs[i].e_rv1) check($sformatf("v%0d_rdata1", i), bus.m1_rdata, vecs[i].e_rdata);
    end

    // Contested lock: m1 streams 16 locked writes, m0 keeps reading 0x40.
    begin
      int  wi;
      logic exp_m1;
      wi = 0;
      for (int c = 0; c < 19; c++) begin
        @(negedge clk);
        drive_idle();
        reset         = 1'b0;
        bus.m1_req    = (wi < 16);
        bus.m1_lock   = 1'b1;
        bus.m1_addr   = 32'h100 + 32'(4 * wi);
        bus.m1_wdata  = 32'h5A5A0000 | 32'(wi);
        bus.m1_wmask  = 4'hF;
        bus.m0_req    = (c >= 1);
        bus.m0_addr   = 32'h40;
        #1;
        exp_m1 = !(c == 4 || c == 9 || c == 14);
        check($sformatf("lock_c%0d_gnt1", c), {31'd0, bus.m1_gnt}, {31'd0, exp_m1});
        check($sformatf("lock_c%0d_gnt0", c), {31'd0, bus.m0_gnt}, {31'd0, !exp_m1});
        check($sformatf("lock_c%0d_rv1", c), {31'd0, bus.m1_rvalid}, 32'd0);
        if (c == 5 || c == 10 || c == 15) begin
          check($sformatf("lock_c%0d_rv0", c), {31'd0, bus.m0_rvalid}, 32'd1);
          check($sformatf("lock_c%0d_rdata0", c), bus.m0_rdata, 32'hDEADBEEF);
        end
        if (bus.m1_gnt) wi++;
      end
      @(negedge clk);
      drive_idle();
      #1;
      for (int i = 0; i < 16; i++) begin
        check($sformatf("lock_mem%0d", i), mem_arr[64 + i], 32'h5A5A0000 | 32'(i));
      end
    end

    // Uncontested lock never expires; contested budget then starts from 1.
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      drive_idle();
      bus.m0_req  = 1'b1;
      bus.m0_lock = 1'b1;
      bus.m0_addr = 32'h0;
      bus.m1_req  = (c >= 20);
      bus.m1_addr = 32'h4;
      #1;
      check($sformatf("free_c%0d_gnt0", c), {31'd0, bus.m0_gnt}, {31'd0, (c != 23)});
      check($sformatf("free_c%0d_gnt1", c), {31'd0, bus.m1_gnt}, {31'd0, (c == 23)});
      if (c == 19) check("free_state", {30'd0, state_dbg}, {30'd0, ST_LOCK0});
    end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #1;
    check("free_exit_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // Lock released while the other master arrives: holder first, then round-robin.
    @(negedge clk);
    drive_idle();
    bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m0_addr = 32'h40;
    #1;
    check("rel_c0_gnt0", {31'd0, bus.m0_gnt}, 32'd1);
    @(negedge clk);
    bus.m0_lock = 1'b0;
    bus.m1_req  = 1'b1; bus.m1_addr = 32'h4;
    #1;
    check("rel_c1_state", {30'd0, state_dbg}, {30'd0, ST_LOCK0});
    check("rel_c1_gnt0", {31'd0, bus.m0_gnt}, 32'd1);
    check("rel_c1_gnt1", {31'd0, bus.m1_gnt}, 32'd0);
    @(negedge clk);
    #1;
    check("rel_c2_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    check("rel_c2_gnt1", {31'd0, bus.m1_gnt}, 32'd1);
    check("rel_c2_gnt0", {31'd0, bus.m0_gnt}, 32'd0);
    check("rel_c2_rv0", {31'd0, bus.m0_rvalid}, 32'd1);
    check("rel_c2_rdata0", bus.m0_rdata, 32'hDEADBEEF);
    @(negedge clk);
    drive_idle();
    #1;
    check("rel_c3_rv1", {31'd0, bus.m1_rvalid}, 32'd1);
    check("rel_c3_rdata1", bus.m1_rdata, 32'hB4B4B4B4);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
